// File: rtl/rptr_level_handler.sv
// rptr_level_handler: async FIFO read-side pointers, empty/almost-empty/count flags, read-valid and underflow; RPTR_UNDERFLOW_STICKY_EN makes underflow sticky
module rptr_level_handler #(
  parameter int PTR_WIDTH = 8,
  parameter int AE_LEVEL  = 4
) (
  input  logic               rclk,
  input  logic               rrstn,
  input  logic               rd_en,
  input  logic [PTR_WIDTH:0] g_wptr_sync,
  output logic [PTR_WIDTH:0] b_rptr,
  output logic [PTR_WIDTH:0] g_rptr,
  output logic               empty,
  output logic               almost_empty,
  output logic [PTR_WIDTH:0] rd_count,
  output logic               rd_accept,
  output logic               rd_valid,
  output logic               underflow
);
  localparam logic [PTR_WIDTH:0] AE_LVL = AE_LEVEL[PTR_WIDTH:0];
  logic [PTR_WIDTH:0] b_wptr_sync, b_rptr_next, g_rptr_next, rd_count_next;
  logic               underflow_next;
  for (genvar i = 0; i <= PTR_WIDTH; i++) begin : g_bin
    assign b_wptr_sync[i] = ^(g_wptr_sync >> i);
  end
  // next pointers, occupancy and underflow from the current read request
  always_comb begin
    rd_accept     = rd_en & ~empty;
    b_rptr_next   = b_rptr + {{PTR_WIDTH{1'b0}}, rd_accept};
    g_rptr_next   = b_rptr_next ^ (b_rptr_next >> 1);
    rd_count_next = b_wptr_sync - b_rptr_next;
`ifdef RPTR_UNDERFLOW_STICKY_EN
    underflow_next = underflow | (rd_en & empty);
`else
    underflow_next = rd_en & empty;
`endif
  end
  // register pointers and flags together so empty carries no extra latency
  always_ff @(posedge rclk or negedge rrstn) begin
    if (!rrstn) begin
      b_rptr       <= '0;
      g_rptr       <= '0;
      empty        <= 1'b1;
      almost_empty <= 1'b1;
      rd_count     <= '0;
      rd_valid     <= 1'b0;
      underflow    <= 1'b0;
    end else begin
      b_rptr       <= b_rptr_next;
      g_rptr       <= g_rptr_next;
      empty        <= g_rptr_next == g_wptr_sync;
      almost_empty <= rd_count_next <= AE_LVL;
      rd_count     <= rd_count_next;
      rd_valid     <= rd_accept;
      underflow    <= underflow_next;
    end
  end
endmodule

// File: tb/tb_rptr_level_handler.sv
// tb_rptr_level_handler: randomized and directed check of rptr_level_handler against an occupancy model
module tb_rptr_level_handler;
  logic       rclk = 0;
  logic       rrstn = 0;
  logic       rd_en = 0;
  logic [3:0] g_wptr_sync = 0;
  logic [3:0] b_rptr, g_rptr, rd_count;
  logic       empty, almost_empty, rd_accept, rd_valid, underflow;
  int total = 0;
  int bad = 0;
  int w = 0;
  int m_r = 0;
  int m_count = 0;
  bit m_empty = 1, m_ae = 1, m_valid = 0, m_uf = 0;
  bit sticky;

  rptr_level_handler #(.PTR_WIDTH(3), .AE_LEVEL(2)) dut (
    .rclk(rclk), .rrstn(rrstn), .rd_en(rd_en), .g_wptr_sync(g_wptr_sync),
    .b_rptr(b_rptr), .g_rptr(g_rptr), .empty(empty), .almost_empty(almost_empty),
    .rd_count(rd_count), .rd_accept(rd_accept), .rd_valid(rd_valid), .underflow(underflow)
  );

  always #5 rclk = ~rclk;

  function automatic logic [3:0] gray(input int b);
    logic [3:0] v;
    v = b[3:0];
    return v ^ (v >> 1);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
    end
  endtask

  // occupancy model: reads accepted only when the model says not empty
  always @(posedge rclk or negedge rrstn) begin
    if (!rrstn) begin
      m_r = 0; m_count = 0; m_empty = 1; m_ae = 1; m_valid = 0; m_uf = 0;
    end else begin
      bit acc;
      acc = rd_en && !m_empty;
      m_uf = sticky ? (m_uf || (rd_en && m_empty)) : (rd_en && m_empty);
      m_r = (m_r + int'(acc)) % 16;
      m_count = ((w - m_r) % 16 + 16) % 16;
      m_empty = m_count == 0;
      m_ae = m_count <= 2;
      m_valid = acc;
    end
  end

  // compare every cycle, away from the clock edge
  always @(negedge rclk) begin
    chk("b_rptr", 32'(b_rptr), 32'(m_r));
    chk("g_rptr", 32'(g_rptr), 32'(gray(m_r)));
    chk("empty", 32'(empty), 32'(m_empty));
    chk("almost_empty", 32'(almost_empty), 32'(m_ae));
    chk("rd_count", 32'(rd_count), 32'(m_count));
    chk("rd_valid", 32'(rd_valid), 32'(m_valid));
    chk("underflow", 32'(underflow), 32'(m_uf));
    chk("rd_accept", 32'(rd_accept), 32'(rd_en && !m_empty));
  end

  task automatic tick(input bit re, input int wn);
    rd_en = re;
    w = wn & 15;
    g_wptr_sync = gray(w);
    @(posedge rclk);
    #2;
  endtask

  task automatic reset_vals(input string tag);
    chk({tag, "_b_rptr"}, 32'(b_rptr), 0);
    chk({tag, "_g_rptr"}, 32'(g_rptr), 0);
    chk({tag, "_empty"}, 32'(empty), 1);
    chk({tag, "_ae"}, 32'(almost_empty), 1);
    chk({tag, "_count"}, 32'(rd_count), 0);
    chk({tag, "_valid"}, 32'(rd_valid), 0);
    chk({tag, "_uf"}, 32'(underflow), 0);
  endtask

  initial begin
`ifdef RPTR_UNDERFLOW_STICKY_EN
    sticky = 1;
`else
    sticky = 0;
`endif
    repeat (2) @(posedge rclk);
    #2;
    reset_vals("rst");
    rrstn = 1;
    for (int k = 0; k < 3; k++) begin
      tick(1, 0);
      chk("s1_empty", 32'(empty), 1);
      chk("s1_b_rptr", 32'(b_rptr), 0);
      chk("s1_valid", 32'(rd_valid), 0);
      chk("s1_uf", 32'(underflow), 1);
    end
    tick(0, 5);
    chk("s2_empty", 32'(empty), 0);
    chk("s2_count5", 32'(rd_count), 5);
    chk("s2_ae0", 32'(almost_empty), 0);
    chk("s2_uf_after", 32'(underflow), sticky ? 1 : 0);
    tick(1, 5);
    chk("s2_count4", 32'(rd_count), 4);
    chk("s2_valid", 32'(rd_valid), 1);
    tick(1, 5);
    chk("s2_count3", 32'(rd_count), 3);
    chk("s2_ae_at3", 32'(almost_empty), 0);
    tick(1, 5);
    chk("s2_count2", 32'(rd_count), 2);
    chk("s2_ae_at2", 32'(almost_empty), 1);
    tick(0, 5);
    chk("s2_valid_drop", 32'(rd_valid), 0);
    tick(1, 5);
    tick(1, 5);
    chk("s2_drained", 32'(empty), 1);
    tick(0, 13);
    chk("s6a_count8", 32'(rd_count), 8);
    repeat (8) tick(1, 13);
    chk("s6a_empty", 32'(empty), 1);
    tick(0, 0);
    tick(1, 0);
    tick(1, 0);
    chk("s3_b15", 32'(b_rptr), 15);
    chk("s3_count1", 32'(rd_count), 1);
    tick(1, 0);
    chk("s3_wrap_b", 32'(b_rptr), 0);
    chk("s3_wrap_g", 32'(g_rptr), 0);
    chk("s3_empty", 32'(empty), 1);
    chk("s3_count0", 32'(rd_count), 0);
    tick(0, 8);
    chk("s6_count8", 32'(rd_count), 8);
    chk("s6_empty0", 32'(empty), 0);
    for (int k = 0; k < 8; k++) begin
      tick(1, 8);
      if (!sticky) chk("s6_no_uf", 32'(underflow), 0);
    end
    chk("s6_empty1", 32'(empty), 1);
    tick(0, 9);
    chk("s4_count1", 32'(rd_count), 1);
    tick(1, 10);
    chk("s4_count_hold", 32'(rd_count), 1);
    chk("s4_empty0", 32'(empty), 0);
    tick(0, 0);
    chk("s4_jump7", 32'(rd_count), 7);
    for (int k = 0; k < 400; k++) begin
      int occ, jmp;
      occ = ((w - m_r) % 16 + 16) % 16;
      jmp = ($urandom % 2 == 0) ? int'($urandom_range(0, 8 - occ)) : 0;
      tick(($urandom % 3) != 0, w + jmp);
    end
    repeat (9) tick(1, w);
    tick(0, m_r + 6);
    tick(1, w);
    chk("s5_count5", 32'(rd_count), 5);
    chk("s5_valid1", 32'(rd_valid), 1);
    #1;
    rrstn = 0;
    w = 0;
    g_wptr_sync = 0;
    rd_en = 0;
    #1;
    reset_vals("s5");
    @(posedge rclk);
    #2;
    rrstn = 1;
    tick(0, 3);
    chk("post_rst_count", 32'(rd_count), 3);
    repeat (2) tick(1, 3);
    @(posedge rclk);
    #2;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
